trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Trap controller directly downstream of the execute-stage exception detector.
//  Registers the 7-bit exception vector and priority-encodes it into an M-mode cause.
//  Holds mepc/mcause/mtval/mtvec/mstatus(MIE,MPIE), sequences pipeline flush and PC redirect.
//  Sits between the E stage and fetch/CSR logic; also executes MRET.
// PARAMETERS
//  N          64           datapath/address width
//  RESET_VEC  64'h0        mtvec reset value (bits[1:0] forced 0)
// PORTS
//  clk            in   1    clock, all state on rising edge
//  reset_n        in   1    asynchronous, active-low reset
//  valid_E        in   1    E-stage instruction valid
//  pc_E           in   N    PC of E-stage instruction
//  DM_addr        in   N    E-stage data address (fault address)
//  exceptSignal   in   7    [0]ld misalign [1]ld access [2]st misalign [3]st access [4]ld page [5]st page [6]breakpoint
//  mret_E         in   1    E-stage instruction is MRET
//  csr_we         in   1    CSR write strobe (E stage)
//  csr_addr       in   12   CSR address for read/write
//  csr_wdata      in   N    CSR write data
//  csr_rdata      out  N    combinational CSR read data
//  flush          out  1    kill F/D/E instructions
//  stall_F        out  1    hold fetch PC
//  redirect_valid out  1    load redirect_pc into fetch PC
//  redirect_pc    out  N    redirect target
//  in_trap        out  1    FSM not in IDLE
// BEHAVIOUR
//  - Reset: state IDLE; flush/stall_F/redirect_valid/in_trap=0; redirect_pc, mepc, mcause, mtval=0;
//    mtvec=RESET_VEC; MIE=0, MPIE=0. Async reset mid-sequence returns to IDLE with outputs low immediately.
//  - FSM: IDLE -> FLUSH -> REDIRECT -> IDLE. FLUSH: flush=1, stall_F=1. REDIRECT: redirect_valid=1,
//    stall_F=0, redirect_pc=target reg. in_trap=1 in FLUSH and REDIRECT. Each non-IDLE state lasts exactly 1 cycle.
//  - Trap entry (IDLE, valid_E, |exceptSignal) at edge T: mepc<=pc_E, mcause<=cause (bit N-1=0),
//    mtval<=DM_addr (pc_E for breakpoint), MPIE<=MIE, MIE<=0, target<={mtvec[N-1:2],2'b00}.
//    flush at T+1, redirect at T+2.
//  - Priority (high->low): bkpt(3) > st misalign(6) > ld misalign(4) > st page(15) > ld page(13)
//    > st access(7) > ld access(5).
//  - MRET (IDLE, valid_E, mret_E, no exception): MIE<=MPIE, MPIE<=1, target<=mepc; same FLUSH->REDIRECT path.
//  - Exception and mret_E same cycle: exception wins, MRET dropped.
//  - valid_E=0: exceptSignal/mret_E ignored. Not IDLE: new exceptions, MRET and csr_we ignored.
//  - CSR map: 0x300 mstatus (MIE bit3, MPIE bit7, others RAZ/WI), 0x305 mtvec, 0x341 mepc,
//    0x342 mcause, 0x343 mtval. Unmapped: read 0, write ignored.
//  - mtvec/mepc writes force bits[1:0]=0. csr_we coincident with trap entry: trap updates of
//    mepc/mcause/mtval/mstatus win; an mtvec write applies, but target uses the old mtvec.
// CONFIGURATION
//  TRAP_MTVAL_EN defined: mtval captured as above and writable via CSR.
//  Undefined: no mtval register; 0x343 reads 0, writes ignored.
// STRUCTURE
//  trap_pkg: exceptSignal bit indices, cause codes, CSR address localparams, state enum.
//  Sub-module trap_prio_enc: combinational 7-bit -> {valid, cause[3:0]} priority encoder.
// TESTING
//  1 ld misalign: valid_E=1, exceptSignal=7'b0000001, pc_E=0x1000, DM_addr=0x2003, mtvec=0x8000
//    -> T+1 flush=1; T+2 redirect_pc=0x8000; mcause=4, mepc=0x1000, mtval=0x2003.
//  2 exceptSignal=7'b1000101 -> mcause=3, mtval=pc_E.
//  3 trap then MRET with MPIE=1 (MIE was 1 pre-trap) -> redirect_pc=mepc, MIE=1, MPIE=1.
//  4 exception + mret_E same cycle -> trap taken, MIE=0; second exception during FLUSH ignored.
//  5 reset_n low during FLUSH -> flush=0 immediately, state IDLE, mtvec=RESET_VEC.
//  6 csr_we mtvec=0x9003 -> read 0x9000; valid_E=0 with exceptSignal=7'h7F -> no trap.

Source files
------------

// File: rtl/trap_pkg.sv
// trap_pkg: shared exception bit indices, M-mode cause codes, CSR addresses and FSM states
package trap_pkg;
    localparam int EX_LD_MIS = 0;
    localparam int EX_LD_ACC = 1;
    localparam int EX_ST_MIS = 2;
    localparam int EX_ST_ACC = 3;
    localparam int EX_LD_PG  = 4;
    localparam int EX_ST_PG  = 5;
    localparam int EX_BKPT   = 6;
    localparam logic [3:0] C_BKPT   = 4'd3;
    localparam logic [3:0] C_LD_MIS = 4'd4;
    localparam logic [3:0] C_LD_ACC = 4'd5;
    localparam logic [3:0] C_ST_MIS = 4'd6;
    localparam logic [3:0] C_ST_ACC = 4'd7;
    localparam logic [3:0] C_LD_PG  = 4'd13;
    localparam logic [3:0] C_ST_PG  = 4'd15;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_e;
endpackage

// File: rtl/trap_if.sv
// trap_if: E-stage / CSR / fetch-redirect signal bundle for the trap controller
interface trap_if #(parameter int N = 64);
    logic         valid_E;
    logic [N-1:0] pc_E;
    logic [N-1:0] DM_addr;
    logic [6:0]   exceptSignal;
    logic         mret_E;
    logic         csr_we;
    logic [11:0]  csr_addr;
    logic [N-1:0] csr_wdata;
    logic [N-1:0] csr_rdata;
    logic         flush;
    logic         stall_F;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         in_trap;
    modport master (output valid_E, pc_E, DM_addr, exceptSignal, mret_E, csr_we, csr_addr, csr_wdata,
                    input  csr_rdata, flush, stall_F, redirect_valid, redirect_pc, in_trap);
    modport slave  (input  valid_E, pc_E, DM_addr, exceptSignal, mret_E, csr_we, csr_addr, csr_wdata,
                    output csr_rdata, flush, stall_F, redirect_valid, redirect_pc, in_trap);
endinterface

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: 7-bit exception vector to {valid, M-mode cause} priority encoder
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic [6:0] exc_i,
    output logic       valid_o,
    output logic [3:0] cause_o
);
    assign valid_o = |exc_i;
    always_comb
        cause_o = exc_i[EX_BKPT]   ? C_BKPT   :
                  exc_i[EX_ST_MIS] ? C_ST_MIS :
                  exc_i[EX_LD_MIS] ? C_LD_MIS :
                  exc_i[EX_ST_PG]  ? C_ST_PG  :
                  exc_i[EX_LD_PG]  ? C_LD_PG  :
                  exc_i[EX_ST_ACC] ? C_ST_ACC :
                  exc_i[EX_LD_ACC] ? C_LD_ACC : 4'd0;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: M-mode trap/MRET controller with CSRs and IDLE->FLUSH->REDIRECT sequencing.
// Define TRAP_MTVAL_EN to implement the mtval register (otherwise 0x343 reads as zero).
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int           N         = 64,
    parameter logic [N-1:0] RESET_VEC = '0
) (
    input logic clk,
    input logic reset_n,
    trap_if.slave bus
);
    state_e       state_q, state_d;
    logic [N-1:0] mepc_q, mcause_q, mtvec_q, target_q, mtval_rd, mstatus_rd;
    logic         mie_q, mpie_q;
    logic         exc_v, idle, take_trap, take_mret, csr_wr;
    logic [3:0]   cause;

    trap_prio_enc u_enc (.exc_i(bus.exceptSignal), .valid_o(exc_v), .cause_o(cause));

    assign idle      = state_q == IDLE;
    assign take_trap = idle && bus.valid_E && exc_v;
    assign take_mret = idle && bus.valid_E && bus.mret_E && !exc_v;
    assign csr_wr    = idle && bus.csr_we;

    always_comb begin
        state_d            = (take_trap || take_mret) ? FLUSH : (state_q == FLUSH) ? REDIRECT : IDLE;
        bus.flush          = state_q == FLUSH;
        bus.stall_F        = state_q == FLUSH;
        bus.redirect_valid = state_q == REDIRECT;
        bus.in_trap        = !idle;
    end

    assign bus.redirect_pc = target_q;

    // CSR writes are applied first so that trap/MRET updates in the same cycle override them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtvec_q  <= {RESET_VEC[N-1:2], 2'b00};
            target_q <= '0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (csr_wr && bus.csr_addr == CSR_MTVEC) mtvec_q <= {bus.csr_wdata[N-1:2], 2'b00};
            if (csr_wr && bus.csr_addr == CSR_MEPC) mepc_q <= {bus.csr_wdata[N-1:2], 2'b00};
            if (csr_wr && bus.csr_addr == CSR_MCAUSE) mcause_q <= bus.csr_wdata;
            if (csr_wr && bus.csr_addr == CSR_MSTATUS) begin
                mie_q  <= bus.csr_wdata[3];
                mpie_q <= bus.csr_wdata[7];
            end
            if (take_trap) begin
                mepc_q   <= bus.pc_E;
                mcause_q <= {{(N-4){1'b0}}, cause};
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
                target_q <= {mtvec_q[N-1:2], 2'b00};
            end
            if (take_mret) begin
                mie_q    <= mpie_q;
                mpie_q   <= 1'b1;
                target_q <= mepc_q;
            end
        end
    end

`ifdef TRAP_MTVAL_EN
    logic [N-1:0] mtval_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mtval_q <= '0;
        else if (take_trap) mtval_q <= bus.exceptSignal[EX_BKPT] ? bus.pc_E : bus.DM_addr;
        else if (csr_wr && bus.csr_addr == CSR_MTVAL) mtval_q <= bus.csr_wdata;
    end
    assign mtval_rd = mtval_q;
`else
    logic unused_dm;
    assign unused_dm = ^bus.DM_addr;
    assign mtval_rd  = '0;
`endif

    always_comb begin
        mstatus_rd    = '0;
        mstatus_rd[3] = mie_q;
        mstatus_rd[7] = mpie_q;
    end

    assign bus.csr_rdata = (bus.csr_addr == CSR_MSTATUS) ? mstatus_rd :
                           (bus.csr_addr == CSR_MTVEC)   ? mtvec_q    :
                           (bus.csr_addr == CSR_MEPC)    ? mepc_q     :
                           (bus.csr_addr == CSR_MCAUSE)  ? mcause_q   :
                           (bus.csr_addr == CSR_MTVAL)   ? mtval_rd   : '0;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed + randomized bench for trap_ctrl against a rule-level reference model
module tb_trap_ctrl;
    localparam logic [63:0] RV = 64'h4004_0103;
`ifdef TRAP_MTVAL_EN
    localparam bit MTV = 1'b1;
`else
    localparam bit MTV = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #10 clk = ~clk;

    trap_if #(.N(64)) bif ();
    trap_ctrl #(.N(64), .RESET_VEC(RV)) dut (.clk(clk), .reset_n(reset_n), .bus(bif));

    int vec = 0;
    int miss = 0;
    int ph;
    logic [63:0] m_mepc, m_mcause, m_mtval, m_mtvec, m_tgt;
    bit m_mie, m_mpie;
    int pri_bit[7]   = '{6, 2, 0, 5, 4, 3, 1};
    int pri_cause[7] = '{3, 6, 4, 15, 13, 7, 5};
    logic [11:0] addrs[7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7ff};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {56'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return MTV ? m_mtval : 64'h0;
            default: return 64'h0;
        endcase
    endfunction

    task automatic m_reset();
        ph = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_tgt = 0;
        m_mtvec = RV & ~64'h3; m_mie = 0; m_mpie = 0;
    endtask

    task automatic m_step();
        logic [63:0] old_tvec = m_mtvec;
        bit old_mie = m_mie;
        bit old_mpie = m_mpie;
        bit idle = (ph == 0);
        bit exc = bif.valid_E && (bif.exceptSignal != 0);
        bit mr = bif.valid_E && bif.mret_E && !exc;
        int cause = 0;
        if (idle && bif.csr_we)
            case (bif.csr_addr)
                12'h300: begin m_mie = bif.csr_wdata[3]; m_mpie = bif.csr_wdata[7]; end
                12'h305: m_mtvec = bif.csr_wdata & ~64'h3;
                12'h341: m_mepc = bif.csr_wdata & ~64'h3;
                12'h342: m_mcause = bif.csr_wdata;
                12'h343: if (MTV) m_mtval = bif.csr_wdata;
                default: ;
            endcase
        if (idle && exc) begin
            for (int i = 6; i >= 0; i--) if (bif.exceptSignal[pri_bit[i]]) cause = pri_cause[i];
            m_mepc = bif.pc_E;
            m_mcause = 64'(cause);
            if (MTV) m_mtval = bif.exceptSignal[6] ? bif.pc_E : bif.DM_addr;
            m_mpie = old_mie;
            m_mie = 0;
            m_tgt = old_tvec;
            ph = 1;
        end else if (idle && mr) begin
            m_mie = old_mpie;
            m_mpie = 1;
            m_tgt = m_mepc;
            ph = 1;
        end else ph = (ph == 1) ? 2 : 0;
    endtask

    task automatic chk_outs();
        chk("flush", bif.flush, ph == 1);
        chk("stall_F", bif.stall_F, ph == 1);
        chk("redirect_valid", bif.redirect_valid, ph == 2);
        chk("in_trap", bif.in_trap, ph != 0);
        if (ph == 2) chk("redirect_pc", bif.redirect_pc, m_tgt);
        chk("csr_rdata", bif.csr_rdata, m_read(bif.csr_addr));
    endtask

    task automatic idle_in();
        bif.valid_E = 0; bif.pc_E = 0; bif.DM_addr = 0; bif.exceptSignal = 0; bif.mret_E = 0;
        bif.csr_we = 0; bif.csr_addr = 12'h342; bif.csr_wdata = 0;
    endtask

    task automatic cyc();
        m_step();
        @(posedge clk);
        @(negedge clk);
        chk_outs();
    endtask

    task automatic lit(input string tag, input logic [11:0] a, input logic [63:0] exp);
        bif.csr_addr = a;
        #1 chk(tag, bif.csr_rdata, exp);
    endtask

    task automatic read_all();
        foreach (addrs[i]) begin
            bif.csr_addr = addrs[i];
            #1 chk("csr_sweep", bif.csr_rdata, m_read(addrs[i]));
        end
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        idle_in(); bif.csr_we = 1; bif.csr_addr = a; bif.csr_wdata = d;
        cyc(); idle_in();
    endtask

    task automatic exc_in(input logic [6:0] e, input logic [63:0] pc, input logic [63:0] da);
        idle_in(); bif.valid_E = 1; bif.exceptSignal = e; bif.pc_E = pc; bif.DM_addr = da;
    endtask

    initial begin
        idle_in();
        m_reset();
        #1 reset_n = 0;
        #5 chk_outs();
        chk("rst_redirect_pc", bif.redirect_pc, 64'h0);
        lit("rst_mtvec", 12'h305, 64'h4004_0100);
        read_all();
        @(negedge clk) reset_n = 1;
        // ld misalign
        csr_write(12'h305, 64'h8000);
        exc_in(7'b0000001, 64'h1000, 64'h2003);
        cyc();
        chk("t1_flush", bif.flush, 1);
        idle_in(); cyc();
        chk("t1_redirect_pc", bif.redirect_pc, 64'h8000);
        cyc();
        lit("t1_mcause", 12'h342, 64'd4);
        lit("t1_mepc", 12'h341, 64'h1000);
        lit("t1_mtval", 12'h343, MTV ? 64'h2003 : 64'h0);
        // breakpoint outranks misaligned accesses
        exc_in(7'b1000101, 64'h1234_5670, 64'hdead);
        cyc(); idle_in(); cyc(); cyc();
        lit("t2_mcause", 12'h342, 64'd3);
        lit("t2_mtval", 12'h343, MTV ? 64'h1234_5670 : 64'h0);
        // trap with MIE=1, then MRET
        csr_write(12'h300, 64'h8);
        exc_in(7'b0000100, 64'h2000, 64'h10);
        cyc(); idle_in(); cyc(); cyc();
        lit("t3_mcause", 12'h342, 64'd6);
        lit("t3_mstatus_trap", 12'h300, 64'h80);
        idle_in(); bif.valid_E = 1; bif.mret_E = 1;
        cyc(); idle_in(); cyc();
        chk("t3_mret_pc", bif.redirect_pc, 64'h2000);
        cyc();
        lit("t3_mstatus_mret", 12'h300, 64'h88);
        // exception + MRET together, then exception during FLUSH
        exc_in(7'b0100000, 64'h3000, 64'h3008); bif.mret_E = 1;
        cyc();
        exc_in(7'b1000000, 64'h4444, 64'h0);
        cyc(); idle_in(); cyc();
        lit("t4_mcause", 12'h342, 64'd15);
        lit("t4_mepc", 12'h341, 64'h3000);
        lit("t4_mstatus", 12'h300, 64'h80);
        // async reset during FLUSH
        exc_in(7'b0000010, 64'h5000, 64'h5004);
        cyc();
        chk("t5_pre_flush", bif.flush, 1);
        idle_in();
        #2 reset_n = 0;
        m_reset();
        #1 chk("t5_flush", bif.flush, 0);
        chk("t5_in_trap", bif.in_trap, 0);
        chk("t5_stall", bif.stall_F, 0);
        lit("t5_mtvec", 12'h305, 64'h4004_0100);
        @(negedge clk) reset_n = 1;
        cyc();
        // mtvec alignment and valid_E gating
        csr_write(12'h305, 64'h9003);
        lit("t6_mtvec", 12'h305, 64'h9000);
        exc_in(7'h7f, 64'h6000, 64'h6000); bif.valid_E = 0; bif.mret_E = 1;
        cyc();
        chk("t6_no_trap", bif.in_trap, 0);
        idle_in(); cyc();
        lit("t6_mcause", 12'h342, 64'd0);
        read_all();
        for (int n = 0; n < 400; n++) begin
            bif.valid_E = 1'($urandom_range(0, 1));
            bif.exceptSignal = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h0;
            bif.mret_E = ($urandom_range(0, 3) == 0);
            bif.pc_E = {$urandom, $urandom};
            bif.DM_addr = {$urandom, $urandom};
            bif.csr_we = !bif.mret_E && ($urandom_range(0, 2) == 0);
            bif.csr_addr = addrs[$urandom_range(0, 6)];
            bif.csr_wdata = {$urandom, $urandom};
            cyc();
            if (n % 16 == 15) begin
                idle_in();
                read_all();
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
